// File: rtl/fifo_pkg.sv
// fifo_pkg: shared mode encodings, width helper and parameter legality check for sync_fifo_v2
package fifo_pkg;
  localparam int FIFO_MODE_STD = 0;
  localparam int FIFO_MODE_FWFT = 1;
  function automatic int clog2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
  function automatic bit fifo_params_ok(input int data_width, input int depth, input int cnt_width,
                                        input int mode, input int afull, input int aempty);
    return data_width >= 1 && depth >= 4 && (depth & (depth - 1)) == 0 &&
           cnt_width >= $clog2(depth) + 1 && (mode == FIFO_MODE_STD || mode == FIFO_MODE_FWFT) &&
           afull >= 1 && afull <= depth && aempty >= 0 && aempty < depth;
  endfunction
endpackage

// File: rtl/sync_fifo_v2_head.sv
// sync_fifo_v2_head: one-word first-word-fall-through head register with load/pop control
module sync_fifo_v2_head #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  pop,
  input  logic                  mem_nonempty,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  load,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  assign load = !flush & (!valid_q | pop) & mem_nonempty;
  assign valid = valid_q;
  assign data = data_q;
  // refill the head whenever it is empty or being popped and memory has a word
  always_comb begin
    valid_d = flush ? 1'b0 : (load | (valid_q & !pop));
    data_d  = flush ? '0 : (load ? mem_rdata : data_q);
  end
  // head state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2: single-clock FIFO with standard/FWFT read, thresholds, error pulses and flush
module sync_fifo_v2 import fifo_pkg::*; #(
  parameter int DATA_WIDTH    = 128,
  parameter int DEPTH         = 1024,
  parameter int CNT_WIDTH     = $clog2(DEPTH) + 1,
  parameter int FWFT          = FIFO_MODE_STD,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [CNT_WIDTH-1:0]  data_avail_cnt
);
  localparam int AW = clog2w(DEPTH);
  if (!fifo_params_ok(DATA_WIDTH, DEPTH, CNT_WIDTH, FWFT, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
    $error("sync_fifo_v2: illegal parameter combination");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  wr_acc, rd_acc, mem_rd;
  logic [DATA_WIDTH-1:0] mem_rdata;
  assign mem_rdata = mem[rd_ptr_q];
  assign full = count_q == CNT_WIDTH'(DEPTH);
  assign almost_full = count_q >= CNT_WIDTH'(AFULL_THRESH);
  assign almost_empty = count_q <= CNT_WIDTH'(AEMPTY_THRESH);
  assign wr_acc = wr_en & !full;
  assign rd_acc = rd_en & !empty;
  assign overflow = overflow_q;
  assign underflow = underflow_q;
  assign data_avail_cnt = count_q;
  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    logic mem_nonempty;
    assign mem_nonempty = (count_q - CNT_WIDTH'(rd_valid)) != '0;
    assign empty = !rd_valid;
    sync_fifo_v2_head #(.DATA_WIDTH(DATA_WIDTH)) u_head (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .pop          (rd_acc),
      .mem_nonempty (mem_nonempty),
      .mem_rdata    (mem_rdata),
      .load         (mem_rd),
      .valid        (rd_valid),
      .data         (rd_data)
    );
  end else begin : g_std
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    assign empty = count_q == '0;
    assign mem_rd = rd_acc;
    assign rd_valid = rd_valid_q;
    assign rd_data = rd_data_q;
    // registered read port: capture the addressed word on an accepted read, else hold
    always_comb begin
      rd_valid_d = !flush & rd_acc;
      rd_data_d  = flush ? '0 : (rd_acc ? mem_rdata : rd_data_q);
    end
    // read output registers
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_valid_q <= 1'b0;
        rd_data_q  <= '0;
      end else begin
        rd_valid_q <= rd_valid_d;
        rd_data_q  <= rd_data_d;
      end
    end
  end
  // next-state for pointers, occupancy and error pulses; flush dominates requests
  always_comb begin
    wr_ptr_d    = flush ? '0 : wr_ptr_q + AW'(wr_acc);
    rd_ptr_d    = flush ? '0 : rd_ptr_q + AW'(mem_rd);
    count_d     = flush ? '0 : count_q + CNT_WIDTH'(wr_acc) - CNT_WIDTH'(rd_acc);
    overflow_d  = !flush & wr_en & full;
    underflow_d = !flush & rd_en & empty;
  end
  // control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  // storage array, left unreset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (wr_acc & !flush) mem[wr_ptr_q] <= wr_data;
  end
endmodule

// File: tb/tb_sync_fifo_v2.sv
// tb_sync_fifo_v2: randomized and directed checks of standard and FWFT instances against queue models
module tb_sync_fifo_v2;
  localparam int DW = 8;
  localparam int SD = 16, S_AF = 12, S_AE = 2;
  localparam int FD = 8, F_AF = 6, F_AE = 1;
  logic clk = 1'b0;
  logic reset, flush, wr_en, rd_en;
  logic [DW-1:0] wr_data;
  logic s_full, s_af, s_ovf, s_rv, s_empty, s_ae, s_unf;
  logic [DW-1:0] s_rdata;
  logic [4:0] s_cnt;
  logic f_full, f_af, f_ovf, f_rv, f_empty, f_ae, f_unf;
  logic [DW-1:0] f_rdata;
  logic [3:0] f_cnt;
  int n_cmp = 0, n_err = 0;
  logic [DW-1:0] sq[$];
  logic [DW-1:0] fq[$];
  bit s_rv_m, s_ovf_m, s_unf_m, f_hv, f_ovf_m, f_unf_m;
  logic [DW-1:0] s_rd_m;

  always #5 clk = ~clk;

  sync_fifo_v2 #(.DATA_WIDTH(DW), .DEPTH(SD), .FWFT(0), .AFULL_THRESH(S_AF), .AEMPTY_THRESH(S_AE)) u_std (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .full(s_full), .almost_full(s_af), .overflow(s_ovf), .rd_en(rd_en), .rd_data(s_rdata),
    .rd_valid(s_rv), .empty(s_empty), .almost_empty(s_ae), .underflow(s_unf), .data_avail_cnt(s_cnt));

  sync_fifo_v2 #(.DATA_WIDTH(DW), .DEPTH(FD), .FWFT(1), .AFULL_THRESH(F_AF), .AEMPTY_THRESH(F_AE)) u_fwft (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .full(f_full), .almost_full(f_af), .overflow(f_ovf), .rd_en(rd_en), .rd_data(f_rdata),
    .rd_valid(f_rv), .empty(f_empty), .almost_empty(f_ae), .underflow(f_unf), .data_avail_cnt(f_cnt));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    sq.delete();
    fq.delete();
    s_rv_m = 0; s_ovf_m = 0; s_unf_m = 0; s_rd_m = '0;
    f_hv = 0; f_ovf_m = 0; f_unf_m = 0;
  endtask

  task automatic model_step();
    int sz, inmem;
    bit pop;
    if (reset) begin
      model_reset();
    end else if (flush) begin
      model_reset();
    end else begin
      s_ovf_m = wr_en && sq.size() == SD;
      s_unf_m = rd_en && sq.size() == 0;
      s_rv_m = rd_en && sq.size() > 0;
      if (s_rv_m) s_rd_m = sq.pop_front();
      if (wr_en && !s_ovf_m) sq.push_back(wr_data);
      sz = fq.size();
      inmem = sz - int'(f_hv);
      pop = rd_en && f_hv;
      f_ovf_m = wr_en && sz == FD;
      f_unf_m = rd_en && !f_hv;
      if (pop) void'(fq.pop_front());
      f_hv = inmem > 0 || (f_hv && !pop);
      if (wr_en && sz < FD) fq.push_back(wr_data);
    end
  endtask

  task automatic check_all();
    chk("s_cnt", s_cnt, sq.size());
    chk("s_full", s_full, sq.size() == SD);
    chk("s_afull", s_af, sq.size() >= S_AF);
    chk("s_aempty", s_ae, sq.size() <= S_AE);
    chk("s_empty", s_empty, sq.size() == 0);
    chk("s_rvalid", s_rv, s_rv_m);
    chk("s_rdata", s_rdata, s_rd_m);
    chk("s_ovf", s_ovf, s_ovf_m);
    chk("s_unf", s_unf, s_unf_m);
    chk("f_cnt", f_cnt, fq.size());
    chk("f_full", f_full, fq.size() == FD);
    chk("f_afull", f_af, fq.size() >= F_AF);
    chk("f_aempty", f_ae, fq.size() <= F_AE);
    chk("f_empty", f_empty, !f_hv);
    chk("f_rvalid", f_rv, f_hv);
    if (f_hv) chk("f_rdata", f_rdata, fq[0]);
    chk("f_ovf", f_ovf, f_ovf_m);
    chk("f_unf", f_unf, f_unf_m);
  endtask

  task automatic step(input bit fl, input bit we, input bit re, input logic [DW-1:0] wd);
    flush = fl; wr_en = we; rd_en = re; wr_data = wd;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    reset = 1; flush = 0; wr_en = 0; rd_en = 0; wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 0;
    // fill past capacity, then drain and underflow
    for (int i = 1; i <= SD + 1; i++) step(0, 1, 0, DW'(i));
    for (int i = 0; i < SD + 1; i++) step(0, 0, 1, 8'h00);
    // steady simultaneous traffic across pointer wrap
    for (int i = 0; i < 3; i++) step(0, 1, 0, DW'(8'h40 + i));
    for (int i = 0; i < 20; i++) step(0, 1, 1, DW'(8'h50 + i));
    for (int i = 0; i < 6; i++) step(0, 0, 1, 8'h00);
    // FWFT fall-through latency, pop and underflow
    step(0, 1, 0, 8'hA5);
    step(0, 0, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h00);
    // flush with a concurrent write
    for (int i = 0; i < 5; i++) step(0, 1, 0, DW'(8'h60 + i));
    step(1, 1, 1, 8'hEE);
    step(0, 0, 1, 8'h00);
    // randomized traffic with alternating write/read bias and rare flushes
    for (int i = 0; i < 2000; i++) begin
      int wp;
      wp = ((i / 250) % 2) ? 30 : 75;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
           DW'($urandom));
    end
    // asynchronous reset between edges in the middle of a burst
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++) step(0, 1, 0, DW'(8'h70 + i));
    flush = 0; wr_en = 1; rd_en = 1; wr_data = 8'h99;
    #3;
    reset = 1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    reset = 0;
    step(0, 1, 0, 8'h3C);
    step(0, 0, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
